ntt_coeff_loader: RTL
=====================

// Module: ntt_coeff_loader
// PURPOSE
//  Upstream feeder for the NTT/INTT processing unit. Accepts one coefficient per beat on a
//  valid/ready stream, reduces it mod Q and places it in a D-slot parallel frame buffer.
//  Placement is natural or bit-reversed. The full frame is presented as a D*N vector with the
//  frame's transform direction (inv) and held until the PU side acknowledges it.
// PARAMETERS
//  N    17     coefficient width in bits
//  D    32     coefficients per frame (power of 2, >= 2)
//  Q    65537  modulus; requires Q < 2^N <= 2Q
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  s_valid     in   1      input coefficient valid
//  s_ready     out  1      loader can accept a coefficient
//  s_data      in   N      coefficient, unsigned, 0..2^N-1
//  s_last      in   1      marks the final beat of a frame
//  s_inv       in   1      frame direction: 0 = NTT, 1 = INTT; sampled on the first beat
//  bitrev      in   1      1 = store beat k at slot bitrev(k); sampled on the first beat
//  vec         out  D*N    frame; slot i occupies bits [N*(i+1)-1 : N*i]
//  vec_inv     out  1      direction of the held frame
//  vec_valid   out  1      frame complete and stable
//  vec_ack     in   1      consumer has taken the frame
//  err         out  1      sticky framing error
//  err_clr     in   1      clears err
// BEHAVIOUR
//  Reset (async, immediate): state=LOAD, idx=0, vec=0, vec_inv=0, vec_valid=0, err=0,
//   s_ready=1 once rst is deasserted.
//  Beat accepted when s_valid && s_ready.
//  Reduction: r = (s_data >= Q) ? s_data - Q : s_data. One conditional subtract, N-bit
//   result, always < Q.
//  FSM:
//   LOAD : s_ready=1.
//     - Beat with idx==0 latches s_inv and bitrev into frame regs (ignored on later beats).
//     - Each beat writes r to slot (bitrev_f ? rev_log2D(idx) : idx); idx++.
//     - Beat with idx==D-1 and s_last=1 -> FULL; idx wraps to 0.
//     - Beat with idx==D-1 and s_last=0 -> err=1; frame discarded; idx=0; stay LOAD.
//     - Beat with s_last=1 and idx<D-1 -> err=1; frame discarded; idx=0; stay LOAD.
//     - Discard means vec_valid stays 0. Slot contents are don't-care until the next full frame.
//   FULL : s_ready=0, vec_valid=1; vec and vec_inv stable.
//     - vec_ack=1 -> LOAD on the next edge; vec_valid=0 and s_ready=1 in the same cycle.
//     - vec is not cleared.
//  Latency: vec_valid rises the cycle after the D-th beat. No same-cycle bypass, so with
//   back-to-back traffic and an ack held at 1 a frame takes D+1 cycles.
//  vec_ack is ignored in LOAD. s_valid is ignored in FULL.
//  err_clr has priority over a same-cycle error set, and the set is lost. err does not
//   block loading.
//  Reset mid-frame or while in FULL drops all partial and held data.
//  vec_inv changes only on the LOAD->FULL transition.
// TESTING
//  T1: after reset, beats 0..31 with data=k, inv=0, bitrev=0, last on beat 31
//      -> vec_valid=1 at cycle 33; slot k==k; vec_inv=0; s_ready=0.
//  T2: same frame with bitrev=1 -> slot 1==16, slot 16==1, slot 3==24, slot 31==31.
//  T3: data 65537, 65540, 131071, 65536 on beats 0..3
//      -> slots 0..3 hold 0, 3, 65534, 65536.
//  T4: s_last on beat 9 -> err=1, vec_valid stays 0; next clean frame loads and presents.
//      Then err_clr=1 -> err=0.
//  T5: frame held, vec_ack held low 10 cycles with s_valid=1 -> no beat taken, vec stable.
//      Then ack -> s_ready=1 next cycle; next frame's s_inv=1 gives vec_inv=1.
//  T6: assert rst at beat 20 and again while in FULL -> all outputs zero immediately.
//      Next frame starts at slot 0.

Source files
------------

// File: rtl/ntt_coeff_loader.sv
// Coefficient loader for the NTT/INTT unit. It reduces each streamed coefficient mod Q and
// places it in natural or bit-reversed order into a D-slot frame, then holds the frame until acked.
module ntt_coeff_loader #(
  parameter int N = 17,
  parameter int D = 32,
  parameter int Q = 65537
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [N-1:0]     s_data,
  input  logic             s_last,
  input  logic             s_inv,
  input  logic             bitrev,
  output logic [D*N-1:0]   vec,
  output logic             vec_inv,
  output logic             vec_valid,
  input  logic             vec_ack,
  output logic             err,
  input  logic             err_clr
);

  localparam int             LOGD = $clog2(D);
  localparam logic [N-1:0]   QN   = N'(Q);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t          r_state;
  logic [LOGD-1:0] r_idx;
  logic            r_bitrev_f;
  logic            r_inv_f;
  logic [N-1:0]    r_slot [D];
  logic            r_vec_inv;
  logic            r_vec_valid;
  logic            r_err;

  logic            w_beat;
  logic            w_last_idx;
  logic            w_err_set;
  logic [N-1:0]    w_red;
  logic [LOGD-1:0] w_slot;

  function automatic logic [LOGD-1:0] rev_idx(input logic [LOGD-1:0] x);
    logic [LOGD-1:0] r;
    for (int b = 0; b < LOGD; b++) r[b] = x[LOGD-1-b];
    return r;
  endfunction

  // Q < 2^N <= 2Q, so one conditional subtract always lands below Q.
  assign w_red      = (s_data >= QN) ? (s_data - QN) : s_data;
  assign w_beat     = s_valid && (r_state == ST_LOAD);
  assign w_last_idx = (r_idx == LOGD'(D - 1));
  assign w_err_set  = w_beat && (s_last != w_last_idx);
  // Slot 0 is its own reverse, so the stale placement flag is harmless on the first beat.
  assign w_slot     = r_bitrev_f ? rev_idx(r_idx) : r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_LOAD;
      r_idx       <= '0;
      r_bitrev_f  <= 1'b0;
      r_inv_f     <= 1'b0;
      r_vec_inv   <= 1'b0;
      r_vec_valid <= 1'b0;
      r_err       <= 1'b0;
      // NOTE: the slot bank drives vec directly, so it must be cleared on reset like any output.
      for (int i = 0; i < D; i++) r_slot[i] <= '0;
    end else begin
      // NOTE: all state updates are non-blocking so every register sees pre-edge values.
      if (err_clr)        r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;

      case (r_state)
        ST_LOAD: begin
          if (w_beat) begin
            if (r_idx == '0) begin
              r_inv_f    <= s_inv;
              r_bitrev_f <= bitrev;
            end
            r_slot[w_slot] <= w_red;
            r_idx          <= s_last ? '0 : r_idx + 1'b1;
            if (s_last && w_last_idx) begin
              r_state     <= ST_FULL;
              r_vec_valid <= 1'b1;
              r_vec_inv   <= r_inv_f;
            end
          end
        end
        ST_FULL: begin
          if (vec_ack) begin
            r_state     <= ST_LOAD;
            r_vec_valid <= 1'b0;
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  // Ready is gated by rst so every output reads zero while reset is held.
  assign s_ready   = !rst && (r_state == ST_LOAD);
  assign vec_inv   = r_vec_inv;
  assign vec_valid = r_vec_valid;
  assign err       = r_err;

  for (genvar i = 0; i < D; i++) begin : g_vec
    assign vec[N*i +: N] = r_slot[i];
  end

endmodule
